// File: rtl/pe_feeder_pkg.sv
// Shared definitions for the PE feeder: datapath width and FSM state encoding.
package pe_feeder_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CALC   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

endpackage

// File: rtl/pe_feeder_dly.sv
// Two-stage valid/data delay; data stages load only with their valid so the
// output data holds its last value while out_valid is low.
module pe_feeder_dly
    import pe_feeder_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         v1_r;
    logic [W-1:0] d1_r;
    logic         v2_r;
    logic [W-1:0] d2_r;

    // Pipeline registers: valid always shifts, data only moves when valid.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1_r <= 1'b0;
            d1_r <= {W{1'b0}};
            v2_r <= 1'b0;
            d2_r <= {W{1'b0}};
        end else begin
            v1_r <= in_valid;
            v2_r <= v1_r;
            if (in_valid) begin
                d1_r <= in_data;
            end
            if (v1_r) begin
                d2_r <= d1_r;
            end
        end
    end

    assign out_valid = v2_r;
    assign out_data  = d2_r;

endmodule

// File: rtl/pe_feeder.sv
// Streams an N-word B vector into the PE local RAM, then N A operands aligned
// with the PE's synchronous RAM read, and captures the PE's N-th result.
module pe_feeder
    import pe_feeder_pkg::*;
#(
    parameter int L_RAM_SIZE = 3
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_W-1:0]     pe_din,
    output logic [L_RAM_SIZE-1:0] pe_addr,
    output logic                  pe_we,
    output logic [DATA_W-1:0]     pe_ain,
    output logic                  pe_valid,
    input  logic                  pe_dvalid,
    input  logic [DATA_W-1:0]     pe_dout,
    output logic [DATA_W-1:0]     res_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  busy
);

    localparam logic [L_RAM_SIZE-1:0] IDX_LAST = {L_RAM_SIZE{1'b1}};
    localparam logic [L_RAM_SIZE-1:0] IDX_ONE  = L_RAM_SIZE'(1);
    localparam logic [L_RAM_SIZE-1:0] IDX_ZERO = {L_RAM_SIZE{1'b0}};

    state_t                  state_r;
    state_t                  next_s;
    logic                    s_ready_r;
    logic                    busy_r;
    logic                    res_valid_r;
    logic [DATA_W-1:0]       res_data_r;
    logic [L_RAM_SIZE-1:0]   idx_r;
    logic [L_RAM_SIZE-1:0]   dcnt_r;
    logic [DATA_W-1:0]       pe_din_r;
    logic [L_RAM_SIZE-1:0]   pe_addr_r;
    logic                    pe_we_r;

    logic                    xfer_s;
    logic                    load_wr_s;
    logic                    calc_rd_s;
    logic                    dv_count_s;
    logic                    dv_last_s;

    // Handshake qualification and next-state decode.
    always_comb begin
        next_s     = state_r;
        xfer_s     = s_valid && s_ready_r;
        load_wr_s  = 1'b0;
        calc_rd_s  = 1'b0;
        dv_count_s = 1'b0;
        dv_last_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_s = ST_LOAD;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_wr_s = xfer_s;
                if (xfer_s && (idx_r == IDX_LAST)) begin
                    next_s = ST_CALC;
                end else begin
                    next_s = ST_LOAD;
                end
            end
            ST_CALC: begin
                calc_rd_s  = xfer_s;
                dv_count_s = pe_dvalid;
                if (xfer_s && (idx_r == IDX_LAST)) begin
                    next_s = ST_DRAIN;
                end else begin
                    next_s = ST_CALC;
                end
            end
            ST_DRAIN: begin
                dv_count_s = pe_dvalid;
                dv_last_s  = pe_dvalid && (dcnt_r == IDX_LAST);
                if (dv_last_s) begin
                    next_s = ST_RESULT;
                end else begin
                    next_s = ST_DRAIN;
                end
            end
            ST_RESULT: begin
                if (res_valid_r && res_ready) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_RESULT;
                end
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // State register; ready/busy/res_valid are registered from the next state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r     <= ST_IDLE;
            s_ready_r   <= 1'b0;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= next_s;
            s_ready_r   <= (next_s == ST_LOAD) || (next_s == ST_CALC);
            busy_r      <= (next_s != ST_IDLE);
            res_valid_r <= (next_s == ST_RESULT);
        end
    end

    // Element index; wraps N-1 -> 0 at each phase change by plain overflow.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idx_r <= IDX_ZERO;
        end else if ((state_r == ST_IDLE) && start) begin
            idx_r <= IDX_ZERO;
        end else if (load_wr_s || calc_rd_s) begin
            idx_r <= idx_r + IDX_ONE;
        end
    end

    // PE result counter, live only from CALC entry until the N-th result.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dcnt_r <= IDX_ZERO;
        end else if ((state_r == ST_IDLE) && start) begin
            dcnt_r <= IDX_ZERO;
        end else if (dv_count_s) begin
            dcnt_r <= dcnt_r + IDX_ONE;
        end
    end

    // RAM write port during LOAD; address also reused for CALC reads.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pe_we_r   <= 1'b0;
            pe_din_r  <= {DATA_W{1'b0}};
            pe_addr_r <= IDX_ZERO;
        end else begin
            pe_we_r <= load_wr_s;
            if (load_wr_s) begin
                pe_din_r <= s_data;
            end
            if (load_wr_s || calc_rd_s) begin
                pe_addr_r <= idx_r;
            end
        end
    end

    // Result capture; holds until the next job produces its N-th result.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            res_data_r <= {DATA_W{1'b0}};
        end else if (dv_last_s) begin
            res_data_r <= pe_dout;
        end
    end

    // A operand lags the address by one cycle to meet the RAM read data.
    pe_feeder_dly #(
        .W (DATA_W)
    ) u_dly (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (calc_rd_s),
        .in_data   (s_data),
        .out_valid (pe_valid),
        .out_data  (pe_ain)
    );

    assign s_ready   = s_ready_r;
    assign busy      = busy_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign pe_din    = pe_din_r;
    assign pe_addr   = pe_addr_r;
    assign pe_we     = pe_we_r;

endmodule
